// File: rtl/imem_responder_pkg.sv
// Purpose : shared constants and FSM state encoding for the imem_responder block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package imem_responder_pkg;

    // Width of one memory word.
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

endpackage

// File: rtl/imem_responder_latency_counter.sv
// Purpose : 4-bit loadable down-counter that paces the BUSY phase of the responder.
// Latency : load/decrement take effect on the next rising edge; o_is_one is decoded from the register.
// Backpressure: none; decrements only while i_en is high and saturates at zero.
// Ports   : clk, rst (async, active-high), i_load/i_load_val (load), i_en (count enable),
//           o_is_one (count == 1).
module latency_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic       o_is_one
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_is_one = (r_count == 4'd1);

endmodule

// File: rtl/imem_responder.sv
// Purpose : multi-cycle word memory answering fetch reads and loader writes, one request at a time.
// Latency : LATENCY cycles from acceptance to the done pulse; malformed requests answer after 1 cycle.
// Backpressure: stall is high while a request is in flight; requests seen during stall are ignored.
// Ports   : clk, rst (async, active-high); req_rd/req_wr/req_addr/req_wdata (request, byte address);
//           stall, done, err, rdata (registered response).
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [15:0]         req_addr,
    input  logic [WORD_W-1:0]   req_wdata,
    output logic                stall,
    output logic                done,
    output logic [WORD_W-1:0]   rdata,
    output logic                err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_cnt_is_one;

    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic                r_stall;
    logic                r_done;
    logic                r_err;
    logic [WORD_W-1:0]   r_rdata;

    // Upper byte-address bits alias onto the array and are deliberately dropped.
    logic                w_unused_addr;
    assign w_unused_addr = ^req_addr[15:ADDR_W+1];

    latency_counter u_latency_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (LOAD_VAL),
        .i_en       (r_state == ST_BUSY),
        .o_is_one   (w_cnt_is_one)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Exactly one op and a word-aligned address is a valid request;
                // any other non-empty request is answered with an error.
                if ((req_rd ^ req_wr) && !req_addr[0]) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end else if (req_rd | req_wr) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_BUSY: begin
                if (w_cnt_is_one) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_stall <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE) || (w_state_nxt == ST_ERR);
            r_err   <= (w_state_nxt == ST_ERR);
            if (w_accept) begin
                r_op_wr <= req_wr;
                r_addr  <= req_addr[ADDR_W:1];
                r_wdata <= req_wdata;
            end
            // Read data lands together with the DONE state so it is valid alongside done.
            if ((r_state == ST_BUSY) && (w_state_nxt == ST_DONE) && !r_op_wr) begin
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    // The write commits at the end of DONE, so a reset earlier in the operation drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if ((r_state == ST_DONE) && r_op_wr) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign stall = r_stall;
    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Purpose : self-checking bench for imem_responder against a transaction-level reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_imem_responder;

    localparam int ADDR_W = 8;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        stall;
    logic        done;
    logic [15:0] rdata;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] ref_rdata;

    imem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (start of the next cycle).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0;
        ref_rdata = 16'h0;
    endtask

    // Present one request in the current (idle) cycle and check every cycle of its response.
    // Ends at the first idle cycle after the response, ready for the next request.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input string name);
        logic        is_err;
        int          len;
        int          idx;
        logic [18:0] got;
        logic [18:0] exp;
        is_err = (rd & wr) | ((rd | wr) & addr[0]);
        idx    = int'(addr >> 1) % DEPTH;
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        n_cmp++;
        got = {stall, done, err, rdata};
        exp = {3'b000, ref_rdata};
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s idle-cyc0: got {stall,done,err,rdata}=%h want %h", name, got, exp);
        end
        if (!(rd | wr)) begin
            step();
            req_rd = 1'b0; req_wr = 1'b0;
            return;
        end
        len = is_err ? 1 : LAT;
        for (int c = 1; c <= len; c++) begin
            step();
            if (c == len) begin
                req_rd = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
            end else begin
                // Lines may wander after acceptance; the DUT must ignore them.
                req_rd = 1'($urandom_range(0, 1)); req_wr = 1'($urandom_range(0, 1));
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end
            exp = {1'b1, (c == len), (is_err && c == len),
                   (c == len && rd && !is_err) ? ref_mem[idx] : ref_rdata};
            got = {stall, done, err, rdata};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s cyc%0d: got {stall,done,err,rdata}=%h want %h", name, c, got, exp);
            end
        end
        if (!is_err) begin
            if (rd) ref_rdata = ref_mem[idx];
            else    ref_mem[idx] = wdata;
        end
        step();
        got = {stall, done, err, rdata};
        exp = {3'b000, ref_rdata};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s after: got {stall,done,err,rdata}=%h want %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        logic [18:0] got;
        rst = 1'b1;
        #2;
        model_clear();
        got = {stall, done, err, rdata};
        n_cmp++;
        if (got !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, 1'b0, 16'($urandom_range(0, 255) << 1), 16'h0, "reset_mem_clear");
        end
    endtask

    task automatic test_basic();
        run_txn(1'b0, 1'b1, 16'h0004, 16'hA5C3, "basic_write");
        run_txn(1'b1, 1'b0, 16'h0004, 16'h0000, "basic_read");
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 1'b0, 16'h0007, 16'h0000, "misaligned_read");
    endtask

    task automatic test_both_high();
        run_txn(1'b0, 1'b1, 16'h0002, 16'h7E57, "both_prewrite");
        run_txn(1'b1, 1'b1, 16'h0002, 16'hDEAD, "both_high");
        run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, "both_readback");
    endtask

    task automatic test_busy_requests();
        logic [18:0] got;
        logic [18:0] exp;
        logic        e_stall;
        logic        e_done;
        logic [15:0] e_rdata;
        run_txn(1'b0, 1'b1, 16'h0004, 16'h1111, "busy_pre4");
        run_txn(1'b0, 1'b1, 16'h0008, 16'h2222, "busy_pre8");
        req_rd = 1'b1; req_wr = 1'b0; req_addr = 16'h0004;
        for (int c = 1; c <= 2 * LAT + 2; c++) begin
            step();
            if (c <= 2 * LAT + 1) begin
                req_rd = 1'b1; req_addr = 16'h0008;
            end else begin
                req_rd = 1'b0; req_addr = 16'h0;
            end
            // First read answers at LAT, held read is taken in the idle cycle LAT+1.
            e_stall = (c != LAT + 1) && (c != 2 * LAT + 2);
            e_done  = (c == LAT) || (c == 2 * LAT + 1);
            if (c == LAT) ref_rdata = ref_mem[2];
            if (c == 2 * LAT + 1) ref_rdata = ref_mem[4];
            e_rdata = ref_rdata;
            exp = {e_stall, e_done, 1'b0, e_rdata};
            got = {stall, done, err, rdata};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL busy_hold cyc%0d: got {stall,done,err,rdata}=%h want %h", c, got, exp);
            end
        end
    endtask

    task automatic test_alias();
        run_txn(1'b0, 1'b1, 16'h0202, 16'h1234, "alias_write");
        run_txn(1'b1, 1'b0, 16'h0002, 16'h0000, "alias_read");
    endtask

    task automatic test_reset_mid_write();
        logic [18:0] got;
        run_txn(1'b1, 1'b0, 16'h0004, 16'h0, "rmw_preread");
        req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF;
        step();
        req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        step();
        rst = 1'b1;
        #1;
        model_clear();
        got = {stall, done, err, rdata};
        n_cmp++;
        if (got !== 19'h0) begin
            n_bad++;
            $display("FAIL rmw_async_clear: got %h want 0", got);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            n_cmp++;
            if ({stall, done} !== 2'b00) begin
                n_bad++;
                $display("FAIL rmw_no_done cyc%0d: got stall,done=%b%b want 00", c, stall, done);
            end
        end
        run_txn(1'b1, 1'b0, 16'h0010, 16'h0, "rmw_readback");
    endtask

    task automatic test_random();
        int          kind;
        logic [15:0] a;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 9);
            a = (16'($urandom) & 16'hFE00) | 16'($urandom_range(0, 15) << 1);
            case (kind)
                0, 1, 2, 3: run_txn(1'b1, 1'b0, a, 16'h0, "rand_read");
                4, 5, 6:    run_txn(1'b0, 1'b1, a, 16'($urandom), "rand_write");
                7:          run_txn(1'b1, 1'b1, a, 16'($urandom), "rand_both");
                8:          run_txn(1'($urandom_range(0, 1)), 1'b1, a | 16'h1, 16'($urandom), "rand_misalign");
                default:    run_txn(1'b0, 1'b0, a, 16'h0, "rand_idle");
            endcase
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_misaligned();
        test_both_high();
        test_busy_requests();
        test_alias();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
